// File: rtl/encrypt_shift_scramble_stream_pkg.sv
// Shared constants and byte helpers for the shift/scramble stream stage.
// Holds the bit permutation table, its derived inverse and the Caesar shift helper.
package encrypt_config;

    typedef logic [7:0] byte_lane_t;
    typedef logic [7:0][2:0] perm_tbl_t;

    localparam int unsigned PERM_0 = 3;
    localparam int unsigned PERM_1 = 6;
    localparam int unsigned PERM_2 = 0;
    localparam int unsigned PERM_3 = 5;
    localparam int unsigned PERM_4 = 1;
    localparam int unsigned PERM_5 = 7;
    localparam int unsigned PERM_6 = 2;
    localparam int unsigned PERM_7 = 4;

    localparam byte_lane_t ASCII_UP_A = 8'd65;
    localparam byte_lane_t ASCII_LO_A = 8'd97;
    localparam logic [5:0] ALPHA_N    = 6'd26;

    // Output bit i takes input bit PERM[i].
    localparam perm_tbl_t PERM = {3'(PERM_7), 3'(PERM_6), 3'(PERM_5), 3'(PERM_4),
                                  3'(PERM_3), 3'(PERM_2), 3'(PERM_1), 3'(PERM_0)};

    function automatic perm_tbl_t invert_perm(perm_tbl_t p);
        perm_tbl_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[p[i]] = 3'(i);
        end
        return r;
    endfunction

    localparam perm_tbl_t PERM_INV = invert_perm(PERM);

    function automatic byte_lane_t permute(byte_lane_t b);
        byte_lane_t r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[PERM[i]];
        end
        return r;
    endfunction

    function automatic byte_lane_t permute_inv(byte_lane_t b);
        byte_lane_t r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[PERM_INV[i]];
        end
        return r;
    endfunction

    // Both operands must already be in 0..25.
    function automatic logic [4:0] add_mod26(logic [4:0] a, logic [4:0] b);
        logic [5:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= ALPHA_N) begin
            t = t - ALPHA_N;
        end
        return t[4:0];
    endfunction

    // dir=1 shifts forward, dir=0 backward; non-letters pass unchanged.
    function automatic byte_lane_t alpha_shift(byte_lane_t c, logic [4:0] s, logic dir);
        logic       is_up;
        logic       is_lo;
        byte_lane_t base;
        logic [5:0] off;
        logic [5:0] t;
        is_up = (c >= ASCII_UP_A) && (c <= ASCII_UP_A + 8'd25);
        is_lo = (c >= ASCII_LO_A) && (c <= ASCII_LO_A + 8'd25);
        base  = is_up ? ASCII_UP_A : ASCII_LO_A;
        off   = 6'(c - base);
        t     = dir ? off + {1'b0, s} : off + ALPHA_N - {1'b0, s};
        if (t >= ALPHA_N) begin
            t = t - ALPHA_N;
        end
        return (is_up || is_lo) ? base + {2'b00, t} : c;
    endfunction

endpackage

// File: rtl/encrypt_lane_xform.sv
// Combinational single-byte transform: shift-then-permute to encrypt,
// inverse-permute-then-unshift to decrypt.
import encrypt_config::*;

module encrypt_lane_xform (
    input  byte_lane_t byte_i,
    input  logic [4:0] shift_i,
    input  logic       mode_i,
    output byte_lane_t byte_o
);

    always_comb begin
        if (mode_i) begin
            byte_o = permute(alpha_shift(byte_i, shift_i, 1'b1));
        end else begin
            byte_o = alpha_shift(permute_inv(byte_i), shift_i, 1'b0);
        end
    end

endmodule

// File: rtl/encrypt_shift_scramble_stream.sv
// Multi-lane shift/scramble stream stage with rolling key offset and a
// two-entry skid buffer (output register plus one skid register).
import encrypt_config::*;

module encrypt_shift_scramble_stream #(
    parameter int unsigned LANES = 4,
    parameter int unsigned KEY_W = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 restart_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [8*LANES-1:0]   in_data_i,
    input  logic [KEY_W-1:0]     in_key_i,
    input  logic [4:0]           shift_base_i,
    input  logic [2:0]           rot_freq_i,
    input  logic                 mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*LANES-1:0]   out_data_o,
    output logic [KEY_W-1:0]     out_key_o,
    output logic                 out_mode_o
);

    localparam int unsigned DW = 8 * LANES;
    localparam int unsigned BW = DW + KEY_W + 1;

    logic          accept;
    logic          emit;
    logic [4:0]    base_mod;
    logic [4:0]    shift_eff;
    logic [DW-1:0] xformed;
    logic [BW-1:0] beat_new;

    logic [2:0]    cnt_q, cnt_d;
    logic [4:0]    offset_q, offset_d;
    logic [BW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;

    assign accept    = in_valid_i && in_ready_q;
    assign emit      = out_valid_q && out_ready_i;
    assign base_mod  = (shift_base_i >= 5'd26) ? shift_base_i - 5'd26 : shift_base_i;
    // A beat accepted alongside restart already sees the cleared offset.
    assign shift_eff = restart_i ? base_mod : add_mod26(base_mod, offset_q);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        encrypt_lane_xform u_xform (
            .byte_i  (in_data_i[8*i +: 8]),
            .shift_i (shift_eff),
            .mode_i  (mode_i),
            .byte_o  (xformed[8*i +: 8])
        );
    end

    assign beat_new = {mode_i, in_key_i, xformed};

    // cnt >= rot_freq also covers a mid-stream drop of rot_freq below cnt.
    always_comb begin
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (restart_i) begin
            cnt_d    = '0;
            offset_d = '0;
        end else if (accept && (rot_freq_i != 3'd0)) begin
            if (({1'b0, cnt_q} + 4'd1) >= {1'b0, rot_freq_i}) begin
                cnt_d    = '0;
                offset_d = (offset_q == 5'd25) ? 5'd0 : offset_q + 5'd1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_valid_q && !emit) begin
            if (accept) begin
                skid_d       = beat_new;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = beat_new;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !(out_valid_d && skid_valid_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            offset_q     <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            offset_q     <= offset_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q[DW-1:0];
    assign out_key_o   = out_q[DW +: KEY_W];
    assign out_mode_o  = out_q[BW-1];

endmodule
